// File: rtl/rv3n_chain.sv
// rv3n_chain: in-order retire buffer in front of the general register file.
// ID allocates up to PNUM entries per cycle, execute writes back out of order by tag,
// and up to PNUM completed head entries retire per cycle, youngest in slot 0.
// Optional feature macro: RV3N_CH_RETCNT_EN adds the 64-bit ch_retire_cnt output.
module rv3n_chain #(
  parameter int unsigned PNUM  = 2,
  parameter int unsigned RGBIT = 5,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TBIT  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PNUM-1:0]       id2ch_valid,
  input  logic [PNUM*RGBIT-1:0] id2ch_rd,
  output logic                  ch2id_ready,
  output logic [PNUM*TBIT-1:0]  ch2id_tag,
  input  logic [PNUM-1:0]       ex2ch_valid,
  input  logic [PNUM*TBIT-1:0]  ex2ch_tag,
  input  logic [PNUM*XLEN-1:0]  ex2ch_data,
  output logic [PNUM*RGBIT-1:0] ch2gsr_order,
  output logic [PNUM*XLEN-1:0]  ch2gsr_data,
`ifdef RV3N_CH_RETCNT_EN
  output logic [63:0]           ch_retire_cnt,
`endif
  output logic                  ch2id_empty
);

  localparam int unsigned CBIT = TBIT + 1;

  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_done;
  logic [RGBIT-1:0]      r_rd   [DEPTH];
  logic [XLEN-1:0]       r_data [DEPTH];
  logic [TBIT-1:0]       r_head;
  logic [TBIT-1:0]       r_tail;
  logic [CBIT-1:0]       r_count;
  logic [PNUM*RGBIT-1:0] r_order;
  logic [PNUM*XLEN-1:0]  r_rdata;
  logic                  r_empty;

  logic [PNUM-1:0]       w_alloc_en;
  logic [PNUM-1:0]       w_ret_en;
  logic [CBIT-1:0]       w_n_alloc;
  logic [CBIT-1:0]       w_n_take;
  logic [CBIT-1:0]       w_n_ret;
  logic [CBIT-1:0]       w_count_next;
  logic                  w_alloc_fire;

  // Ready when at least PNUM entries are free; tags are the next PNUM tail slots.
  always_comb begin
    ch2id_ready = (CBIT'(DEPTH) - r_count) >= CBIT'(PNUM);
    ch2id_tag   = '0;
    for (int i = 0; i < PNUM; i++) begin
      ch2id_tag[i*TBIT +: TBIT] = r_tail + TBIT'(i);
    end
  end

  // Leading-ones count of the allocate request; bits past the first zero are ignored.
  always_comb begin
    logic run;
    run        = 1'b1;
    w_alloc_en = '0;
    w_n_alloc  = '0;
    for (int i = 0; i < PNUM; i++) begin
      run           = run & id2ch_valid[i];
      w_alloc_en[i] = run;
      if (run) w_n_alloc = w_n_alloc + CBIT'(1);
    end
  end

  // Consecutive valid&done entries from head, capped at PNUM.
  always_comb begin
    logic            run;
    logic [TBIT-1:0] idx;
    run      = 1'b1;
    w_ret_en = '0;
    w_n_ret  = '0;
    for (int k = 0; k < PNUM; k++) begin
      idx         = r_head + TBIT'(k);
      run         = run & r_valid[idx] & r_done[idx];
      w_ret_en[k] = run;
      if (run) w_n_ret = w_n_ret + CBIT'(1);
    end
  end

  // Occupancy bookkeeping; retired slots only become free for ready next cycle.
  always_comb begin
    w_alloc_fire = ch2id_ready & (w_n_alloc != '0);
    w_n_take     = ch2id_ready ? w_n_alloc : '0;
    w_count_next = r_count + w_n_take - w_n_ret;
  end

  // Entry storage: writeback (higher port wins), then retire clear, then allocate.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_done  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_rd[e]   <= '0;
        r_data[e] <= '0;
      end
    end else begin
      for (int p = 0; p < PNUM; p++) begin
        if (ex2ch_valid[p] && r_valid[ex2ch_tag[p*TBIT +: TBIT]]) begin
          r_done[ex2ch_tag[p*TBIT +: TBIT]] <= 1'b1;
          r_data[ex2ch_tag[p*TBIT +: TBIT]] <= ex2ch_data[p*XLEN +: XLEN];
        end
      end
      for (int k = 0; k < PNUM; k++) begin
        if (w_ret_en[k]) begin
          r_valid[r_head + TBIT'(k)] <= 1'b0;
          r_done[r_head + TBIT'(k)]  <= 1'b0;
        end
      end
      if (w_alloc_fire) begin
        for (int i = 0; i < PNUM; i++) begin
          if (w_alloc_en[i]) begin
            r_valid[r_tail + TBIT'(i)] <= 1'b1;
            r_done[r_tail + TBIT'(i)]  <= 1'b0;
            r_rd[r_tail + TBIT'(i)]    <= id2ch_rd[i*RGBIT +: RGBIT];
          end
        end
      end
    end
  end

  // Pointers, occupancy and the registered retire bus (oldest in slot PNUM-1).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_order <= '0;
      r_rdata <= '0;
      r_empty <= 1'b1;
    end else begin
      r_head  <= r_head + TBIT'(w_n_ret);
      r_tail  <= r_tail + TBIT'(w_n_take);
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      for (int k = 0; k < PNUM; k++) begin
        if (w_ret_en[k]) begin
          r_order[(PNUM-1-k)*RGBIT +: RGBIT] <= r_rd[r_head + TBIT'(k)];
          r_rdata[(PNUM-1-k)*XLEN +: XLEN]   <= r_data[r_head + TBIT'(k)];
        end else begin
          r_order[(PNUM-1-k)*RGBIT +: RGBIT] <= '0;
          r_rdata[(PNUM-1-k)*XLEN +: XLEN]   <= '0;
        end
      end
    end
  end

  assign ch2gsr_order = r_order;
  assign ch2gsr_data  = r_rdata;
  assign ch2id_empty  = r_empty;

`ifdef RV3N_CH_RETCNT_EN
  logic [63:0] r_retire_cnt;

  // Running total of retired entries, rd=0 included, wrapping at 2^64.
  always_ff @(posedge clk) begin
    if (!rst) r_retire_cnt <= '0;
    else      r_retire_cnt <= r_retire_cnt + 64'(w_n_ret);
  end

  assign ch_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_rv3n_chain.sv
// Bench for rv3n_chain: queue-based reference model of the retire buffer.
module tb_rv3n_chain;

  localparam int PNUM  = 2;
  localparam int RG    = 5;
  localparam int XL    = 32;
  localparam int DEPTH = 8;
  localparam int TB    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [PNUM-1:0]     id2ch_valid;
  logic [PNUM*RG-1:0]  id2ch_rd;
  logic                ch2id_ready;
  logic [PNUM*TB-1:0]  ch2id_tag;
  logic [PNUM-1:0]     ex2ch_valid;
  logic [PNUM*TB-1:0]  ex2ch_tag;
  logic [PNUM*XL-1:0]  ex2ch_data;
  logic [PNUM*RG-1:0]  ch2gsr_order;
  logic [PNUM*XL-1:0]  ch2gsr_data;
  logic                ch2id_empty;
`ifdef RV3N_CH_RETCNT_EN
  logic [63:0]         ch_retire_cnt;
`endif

  rv3n_chain dut (
    .clk(clk), .rst(rst),
    .id2ch_valid(id2ch_valid), .id2ch_rd(id2ch_rd),
    .ch2id_ready(ch2id_ready), .ch2id_tag(ch2id_tag),
    .ex2ch_valid(ex2ch_valid), .ex2ch_tag(ex2ch_tag), .ex2ch_data(ex2ch_data),
    .ch2gsr_order(ch2gsr_order), .ch2gsr_data(ch2gsr_data),
`ifdef RV3N_CH_RETCNT_EN
    .ch_retire_cnt(ch_retire_cnt),
`endif
    .ch2id_empty(ch2id_empty)
  );

  always #5 clk = ~clk;

  // Reference model: program-order queue of in-flight instructions.
  typedef struct {
    logic [RG-1:0] rd;
    bit            done;
    logic [XL-1:0] data;
  } ent_t;

  ent_t               q[$];
  int                 m_head;
  logic [63:0]        m_ret;
  logic [PNUM*RG-1:0] exp_order;
  logic [PNUM*XL-1:0] exp_data;
  int                 n_chk = 0;
  int                 n_err = 0;

  function automatic logic [PNUM*TB-1:0] model_tags();
    logic [PNUM*TB-1:0] t;
    t = '0;
    for (int i = 0; i < PNUM; i++) t[i*TB +: TB] = TB'((m_head + q.size() + i) % DEPTH);
    return t;
  endfunction

  function automatic logic model_ready();
    return (DEPTH - q.size()) >= PNUM;
  endfunction

  // Advance one clock edge, updating the model from the inputs now applied.
  task automatic cycle();
    int                 nret;
    int                 j;
    bit                 rdy;
    ent_t               e;
    logic [TB-1:0]      t;
    logic [PNUM*RG-1:0] eo;
    logic [PNUM*XL-1:0] ed;
    eo = '0; ed = '0; nret = 0;
    if (!rst) begin
      q.delete(); m_head = 0; m_ret = '0;
    end else begin
      rdy = model_ready();
      while (nret < PNUM && nret < q.size() && q[nret].done) begin
        eo[(PNUM-1-nret)*RG +: RG] = q[nret].rd;
        ed[(PNUM-1-nret)*XL +: XL] = q[nret].data;
        nret++;
      end
      for (int p = 0; p < PNUM; p++) begin
        if (ex2ch_valid[p]) begin
          t = ex2ch_tag[p*TB +: TB];
          j = (int'(t) - m_head + DEPTH) % DEPTH;
          if (j < q.size()) begin
            q[j].done = 1'b1;
            q[j].data = ex2ch_data[p*XL +: XL];
          end
        end
      end
      repeat (nret) void'(q.pop_front());
      m_head = (m_head + nret) % DEPTH;
      m_ret  = m_ret + 64'(nret);
      if (rdy) begin
        for (int i = 0; i < PNUM; i++) begin
          if (!id2ch_valid[i]) break;
          e.rd = id2ch_rd[i*RG +: RG]; e.done = 1'b0; e.data = '0;
          q.push_back(e);
        end
      end
    end
    exp_order = eo;
    exp_data  = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id2ch_valid = '0; id2ch_rd = '0;
    ex2ch_valid = '0; ex2ch_tag = '0; ex2ch_data = '0;
  endtask

  // Complete everything in flight and let it retire, with a bounded loop.
  task automatic drain();
    int guard;
    guard = 0;
    idle_inputs();
    while (q.size() != 0 && guard < 40) begin
      ex2ch_valid = '0;
      for (int p = 0; p < PNUM; p++) begin
        if (p < q.size()) begin
          ex2ch_valid[p]          = 1'b1;
          ex2ch_tag[p*TB +: TB]   = TB'((m_head + p) % DEPTH);
          ex2ch_data[p*XL +: XL]  = $urandom;
        end
      end
      cycle();
      guard++;
    end
    idle_inputs();
    cycle();
    n_chk++;
    if (ch2id_empty !== 1'b1 || q.size() != 0 || ch2gsr_order !== '0) begin
      n_err++;
      $display("FAIL drain empty=%b order=%h model_size=%0d expected empty=1 order=0 size=0",
               ch2id_empty, ch2gsr_order, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    cycle(); cycle();
    rst = 1'b1;
    n_chk++;
    if (ch2id_empty !== 1'b1 || ch2id_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_flags empty=%b ready=%b expected 1 1", ch2id_empty, ch2id_ready);
    end
    n_chk++;
    if (ch2gsr_order !== '0 || ch2gsr_data !== '0) begin
      n_err++; $display("FAIL reset_bus order=%h data=%h expected 0 0", ch2gsr_order, ch2gsr_data);
    end
    n_chk++;
    if (ch2id_tag !== 6'b001_000) begin
      n_err++; $display("FAIL reset_tags got %b expected 001000", ch2id_tag);
    end
    cycle();
    n_chk++;
    if (ch2id_empty !== 1'b1 || ch2gsr_order !== '0) begin
      n_err++; $display("FAIL idle empty=%b order=%h expected 1 0", ch2id_empty, ch2gsr_order);
    end
  endtask

  task automatic test_out_of_order();
    id2ch_valid = 2'b11; id2ch_rd = {5'd6, 5'd5};
    cycle();
    id2ch_valid = '0;
    ex2ch_valid = 2'b01; ex2ch_tag = {3'd0, 3'd1}; ex2ch_data = {32'h0, 32'hB};
    cycle();
    n_chk++;
    if (ch2gsr_order !== '0 || exp_order !== '0) begin
      n_err++; $display("FAIL ooo_early1 order=%h expected 0", ch2gsr_order);
    end
    ex2ch_tag = {3'd0, 3'd0}; ex2ch_data = {32'h0, 32'hA};
    cycle();
    n_chk++;
    if (ch2gsr_order !== '0) begin
      n_err++; $display("FAIL ooo_early2 order=%h expected 0", ch2gsr_order);
    end
    ex2ch_valid = '0;
    cycle();
    n_chk++;
    if (ch2gsr_order !== {5'd5, 5'd6} || ch2gsr_data !== {32'hA, 32'hB}) begin
      n_err++; $display("FAIL ooo_retire order=%h data=%h expected %h %h",
                        ch2gsr_order, ch2gsr_data, {5'd5, 5'd6}, {32'hA, 32'hB});
    end
    cycle();
    n_chk++;
    if (ch2gsr_order !== '0 || ch2gsr_data !== '0 || ch2id_empty !== 1'b1) begin
      n_err++; $display("FAIL ooo_after order=%h data=%h empty=%b expected 0 0 1",
                        ch2gsr_order, ch2gsr_data, ch2id_empty);
    end
  endtask

  task automatic test_same_rd();
    logic [PNUM*TB-1:0] tags;
    logic [XL-1:0]      r3;
    tags = model_tags();
    id2ch_valid = 2'b11; id2ch_rd = {5'd3, 5'd3};
    cycle();
    id2ch_valid = '0;
    ex2ch_valid = 2'b11; ex2ch_tag = tags; ex2ch_data = {32'h22, 32'h11};
    cycle();
    ex2ch_valid = '0;
    cycle();
    n_chk++;
    if (ch2gsr_order !== {5'd3, 5'd3} || ch2gsr_data !== {32'h11, 32'h22}) begin
      n_err++; $display("FAIL same_rd_bus order=%h data=%h expected %h %h",
                        ch2gsr_order, ch2gsr_data, {5'd3, 5'd3}, {32'h11, 32'h22});
    end
    r3 = '0;
    for (int s = PNUM - 1; s >= 0; s--) begin
      if (ch2gsr_order[s*RG +: RG] == 5'd3) r3 = ch2gsr_data[s*XL +: XL];
    end
    n_chk++;
    if (r3 !== 32'h22) begin
      n_err++; $display("FAIL same_rd_regfile r3=%h expected 00000022", r3);
    end
    cycle();
  endtask

  task automatic test_full();
    logic [PNUM*TB-1:0] tags_before;
    for (int c = 0; c < 4; c++) begin
      id2ch_valid = 2'b11;
      id2ch_rd    = {RG'($urandom_range(1, 31)), RG'($urandom_range(1, 31))};
      cycle();
    end
    n_chk++;
    if (ch2id_ready !== 1'b0 || q.size() != DEPTH) begin
      n_err++; $display("FAIL full_ready ready=%b model_size=%0d expected 0 8", ch2id_ready, q.size());
    end
    tags_before = ch2id_tag;
    id2ch_valid = 2'b11; id2ch_rd = {5'd9, 5'd9};
    cycle();
    id2ch_valid = '0;
    n_chk++;
    if (ch2id_ready !== 1'b0 || ch2id_tag !== model_tags() || ch2id_tag !== tags_before
        || ch2id_empty !== 1'b0) begin
      n_err++; $display("FAIL full_drop ready=%b tag=%b expected 0 %b", ch2id_ready, ch2id_tag, model_tags());
    end
    ex2ch_valid = 2'b01; ex2ch_tag = {3'd0, TB'(m_head)}; ex2ch_data = {32'h0, 32'hC0DE};
    cycle();
    ex2ch_valid = '0;
    cycle();
    n_chk++;
    if (ch2gsr_order !== exp_order || ch2gsr_data !== exp_data || ch2gsr_data[XL +: XL] !== 32'hC0DE
        || ch2gsr_order[RG-1:0] !== '0) begin
      n_err++; $display("FAIL full_head_retire order=%h data=%h expected %h %h",
                        ch2gsr_order, ch2gsr_data, exp_order, exp_data);
    end
    n_chk++;
    if (ch2id_ready !== 1'b0) begin
      n_err++; $display("FAIL full_count7_ready got %b expected 0", ch2id_ready);
    end
    ex2ch_valid = 2'b01; ex2ch_tag = {3'd0, TB'(m_head)}; ex2ch_data = {32'h0, 32'hBEEF};
    cycle();
    ex2ch_valid = '0;
    cycle();
    n_chk++;
    if (ch2id_ready !== 1'b1 || ch2gsr_order !== exp_order || ch2gsr_data !== exp_data) begin
      n_err++; $display("FAIL full_count6 ready=%b order=%h data=%h expected 1 %h %h",
                        ch2id_ready, ch2gsr_order, ch2gsr_data, exp_order, exp_data);
    end
    drain();
  endtask

  task automatic test_random_wrap();
    for (int r = 0; r < 40; r++) begin
      id2ch_valid = PNUM'($urandom_range(0, 3));
      id2ch_rd    = {RG'($urandom_range(0, 31)), RG'($urandom_range(0, 31))};
      ex2ch_valid = '0;
      for (int p = 0; p < PNUM; p++) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          ex2ch_valid[p]        = 1'b1;
          ex2ch_tag[p*TB +: TB] = TB'((m_head + $urandom_range(0, q.size() - 1)) % DEPTH);
        end else if ($urandom_range(0, 5) == 0) begin
          ex2ch_valid[p]        = 1'b1;
          ex2ch_tag[p*TB +: TB] = TB'($urandom_range(0, DEPTH - 1));
        end
        ex2ch_data[p*XL +: XL] = $urandom;
      end
      cycle();
      n_chk++;
      if (ch2gsr_order !== exp_order || ch2gsr_data !== exp_data) begin
        n_err++; $display("FAIL rand_bus r=%0d order=%h data=%h expected %h %h",
                          r, ch2gsr_order, ch2gsr_data, exp_order, exp_data);
      end
      n_chk++;
      if (ch2id_ready !== model_ready() || ch2id_tag !== model_tags()
          || ch2id_empty !== (q.size() == 0)) begin
        n_err++; $display("FAIL rand_ctl r=%0d ready=%b tag=%b empty=%b expected %b %b %b",
                          r, ch2id_ready, ch2id_tag, ch2id_empty, model_ready(), model_tags(), q.size() == 0);
      end
`ifdef RV3N_CH_RETCNT_EN
      n_chk++;
      if (ch_retire_cnt !== m_ret) begin
        n_err++; $display("FAIL rand_retcnt r=%0d got %0d expected %0d", r, ch_retire_cnt, m_ret);
      end
`endif
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      id2ch_valid = 2'b11;
      id2ch_rd    = {RG'($urandom_range(1, 31)), RG'($urandom_range(1, 31))};
      cycle();
    end
    id2ch_valid = '0;
    ex2ch_valid = 2'b11;
    ex2ch_tag   = {TB'((m_head + 1) % DEPTH), TB'(m_head)};
    ex2ch_data  = {32'h1234, 32'h5678};
    cycle();
    ex2ch_valid = '0;
`ifdef RV3N_CH_RETCNT_EN
    n_chk++;
    if (ch_retire_cnt !== m_ret) begin
      n_err++; $display("FAIL retcnt_before_reset got %0d expected %0d", ch_retire_cnt, m_ret);
    end
`endif
    rst = 1'b0;
    cycle();
    n_chk++;
    if (ch2gsr_order !== '0 || ch2gsr_data !== '0 || ch2id_empty !== 1'b1) begin
      n_err++; $display("FAIL reset_mid order=%h data=%h empty=%b expected 0 0 1",
                        ch2gsr_order, ch2gsr_data, ch2id_empty);
    end
`ifdef RV3N_CH_RETCNT_EN
    n_chk++;
    if (ch_retire_cnt !== 64'd0) begin
      n_err++; $display("FAIL retcnt_after_reset got %0d expected 0", ch_retire_cnt);
    end
`endif
    rst = 1'b1;
    cycle();
    n_chk++;
    if (ch2id_ready !== 1'b1 || ch2id_tag !== 6'b001_000 || ch2gsr_order !== '0) begin
      n_err++; $display("FAIL reset_mid_after ready=%b tag=%b order=%h expected 1 001000 0",
                        ch2id_ready, ch2id_tag, ch2gsr_order);
    end
  endtask

  initial begin
    test_reset();
    test_out_of_order();
    test_same_rd();
    test_full();
    test_random_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
